input_unpack_seq: RTL

- Parametrised, handshaked successor to the bit-fusion input sorter.
- Accepts one DATA_W-bit activation buffer word per transaction and unpacks it over 1, 2 or 4 output beats, depending on the weight bitwidth. Each beat is aligned and replicated into fusion-unit lane order.
- Sits between the input buffer read port and the fusion-unit array.
- Adds valid/ready flow control, per-word mode latching, a last-beat flag and illegal-mode detection.

---
 rtl/input_unpack_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/input_unpack_seq.sv
// Handshaked activation unpacker: one DATA_W word in, 1/2/4 (or 8) lane-ordered beats out.
// Build option UNPACK_1BIT_EN turns mode 11 into a legal 1-bit mode with 8 beats.
module input_unpack_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        weight_bitwidth,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sorted_data,
  output logic              out_last,
  output logic [2:0]        out_beat,
  output logic              err
);

  localparam int LANES = DATA_W / 8;

  typedef enum logic [1:0] {
    MODE_8B = 2'b00,
    MODE_4B = 2'b01,
    MODE_2B = 2'b10,
    MODE_1B = 2'b11
  } mode_t;

  logic [DATA_W-1:0] word_q;
  logic [1:0]        mode_q;
  logic              accept;
  logic              advance;
  logic              finish;
  logic [2:0]        nxt_beat;

  // Index of the final beat for a given mode.
  function automatic logic [2:0] last_idx(input logic [1:0] m);
    logic [2:0] r;
    r = 3'd0;
    case (mode_t'(m))
      MODE_8B: r = 3'd0;
      MODE_4B: r = 3'd1;
      MODE_2B: r = 3'd3;
      default: begin
`ifdef UNPACK_1BIT_EN
        r = 3'd7;
`else
        r = 3'd0;
`endif
      end
    endcase
    return r;
  endfunction

  function automatic logic mode_illegal(input logic [1:0] m);
`ifdef UNPACK_1BIT_EN
    return 1'b0;
`else
    return (m == 2'b11);
`endif
  endfunction

  // Build beat k of word w: pick the slice for that beat and replicate each
  // weight-width field across its 8-bit fusion lane.
  function automatic logic [DATA_W-1:0] unpack_beat(
    input logic [DATA_W-1:0] w,
    input logic [1:0]        m,
    input logic [2:0]        k
  );
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] sh;
    logic [7:0]        b;
    r  = '0;
    sh = '0;
    b  = '0;
    case (mode_t'(m))
      MODE_8B: r = w;
      MODE_4B: begin
        sh = w >> (int'(k[0]) * (DATA_W / 2));
        for (int j = 0; j < LANES / 2; j++) begin
          b = sh[8*j +: 8];
          r[16*j +: 16] = {{2{b[7:6]}}, {2{b[3:2]}}, {2{b[5:4]}}, {2{b[1:0]}}};
        end
      end
      MODE_2B: begin
        sh = w >> (int'(k[1:0]) * (DATA_W / 4));
        for (int i = 0; i < LANES; i++) begin
          r[8*i +: 8] = {4{sh[2*i +: 2]}};
        end
      end
      default: begin
`ifdef UNPACK_1BIT_EN
        sh = w >> (int'(k) * (DATA_W / 8));
        for (int i = 0; i < LANES; i++) begin
          r[8*i +: 8] = {8{sh[i]}};
        end
`else
        r = '0;
`endif
      end
    endcase
    return r;
  endfunction

  // Ready when idle or when the final beat leaves this cycle, so words stream without a bubble.
  assign in_ready = !out_valid || (out_ready && out_last);
  assign accept   = in_valid && in_ready;
  assign advance  = out_valid && out_ready && !out_last;
  assign finish   = out_valid && out_ready && out_last;
  assign nxt_beat = out_beat + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q      <= '0;
      mode_q      <= 2'b00;
      out_valid   <= 1'b0;
      sorted_data <= '0;
      out_last    <= 1'b0;
      out_beat    <= 3'd0;
      err         <= 1'b0;
    end else begin
      if (accept) begin
        word_q      <= in_data;
        mode_q      <= weight_bitwidth;
        out_valid   <= 1'b1;
        sorted_data <= unpack_beat(in_data, weight_bitwidth, 3'd0);
        out_beat    <= 3'd0;
        out_last    <= (last_idx(weight_bitwidth) == 3'd0);
        if (mode_illegal(weight_bitwidth)) begin
          err <= 1'b1;
        end
      end else if (advance) begin
        out_beat    <= nxt_beat;
        sorted_data <= unpack_beat(word_q, mode_q, nxt_beat);
        out_last    <= (nxt_beat == last_idx(mode_q));
      end else if (finish) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
